// File: rtl/tcm_dma_pkg.sv
// ============================================================================
// Module : tcm_dma_pkg
// Brief  : Shared state encoding and transfer-mode constants for tcm_dma.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tcm_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_dp.sv
// ============================================================================
// Module : sram_dp
// Brief  : Dual-port TCM BRAM with byte enables; port A reports read-data
//          valid, which stays high until port A's next access.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_dp #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                a_en_i,
    input  logic                a_we_i,
    input  logic [XLEN/8-1:0]   a_be_i,
    input  logic [ADDRW-1:0]    a_addr_i,
    input  logic [XLEN-1:0]     a_data_i,
    output logic [XLEN-1:0]     a_data_o,
    output logic                a_ready_o,
    input  logic                b_en_i,
    input  logic                b_we_i,
    input  logic [XLEN/8-1:0]   b_be_i,
    input  logic [ADDRW-1:0]    b_addr_i,
    input  logic [XLEN-1:0]     b_data_i,
    output logic [XLEN-1:0]     b_data_o
);

    logic [XLEN-1:0] mem [2**ADDRW];

    always_ff @(posedge clk_i) begin
        if (a_en_i) begin
            if (a_we_i) begin
                for (int k = 0; k < XLEN/8; k++) begin
                    if (a_be_i[k]) mem[a_addr_i][k*8 +: 8] <= a_data_i[k*8 +: 8];
                end
            end else begin
                a_data_o <= mem[a_addr_i];
            end
        end
        if (b_en_i) begin
            if (b_we_i) begin
                for (int k = 0; k < XLEN/8; k++) begin
                    if (b_be_i[k]) mem[b_addr_i][k*8 +: 8] <= b_data_i[k*8 +: 8];
                end
            end else begin
                b_data_o <= mem[b_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       a_ready_o <= 1'b0;
        else if (a_en_i) a_ready_o <= ~a_we_i;
    end

endmodule

`default_nettype wire

// File: rtl/tcm_dma.sv
// ============================================================================
// Module : tcm_dma
// Brief  : Word copy / fill DMA engine driving one port of the TCM BRAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcm_dma
    import tcm_dma_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ADDRW = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [ADDRW-1:0]    src_i,
    input  logic [ADDRW-1:0]    dst_i,
    input  logic [ADDRW:0]      len_i,
    input  logic [XLEN-1:0]     fill_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic [ADDRW:0]      count_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [ADDRW-1:0]    mem_addr_o,
    output logic [XLEN-1:0]     mem_data_o,
    input  logic [XLEN-1:0]     mem_data_i,
    input  logic                mem_ready_i
);

    localparam logic [ADDRW-1:0] ONE_A = {{(ADDRW-1){1'b0}}, 1'b1};
    localparam logic [ADDRW:0]   ONE_C = {{ADDRW{1'b0}}, 1'b1};

    state_t            state;
    logic              mode;
    logic [ADDRW-1:0]  src_ptr;
    logic [ADDRW-1:0]  dst_ptr;
    logic [ADDRW:0]    len;
    logic [XLEN-1:0]   fill;
    logic              abort_pend;

    logic [ADDRW:0]    count_next;
    logic              last_word;
    logic              abort_now;

    assign count_next = count_o + ONE_C;
    assign last_word  = (count_next == len);
    // Abort is remembered through the read half so it is only acted on once the word is written.
    assign abort_now  = abort_pend | abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            mode       <= MODE_COPY;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            len        <= '0;
            fill       <= '0;
            abort_pend <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            aborted_o  <= 1'b0;
            count_o    <= '0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                    aborted_o <= 1'b0;
                    mem_en_o  <= 1'b0;
                    mem_we_o  <= 1'b0;
                    mem_be_o  <= '0;
                    if (start_i) begin
                        mode       <= mode_i;
                        src_ptr    <= src_i;
                        dst_ptr    <= dst_i;
                        len        <= len_i;
                        fill       <= fill_i;
                        count_o    <= '0;
                        abort_pend <= 1'b0;
                        busy_o     <= 1'b1;
                        if (len_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else if (mode_i == MODE_COPY) begin
                            state      <= ST_RD_REQ;
                            mem_en_o   <= 1'b1;
                            mem_addr_o <= src_i;
                        end else begin
                            state      <= ST_WR;
                            mem_en_o   <= 1'b1;
                            mem_we_o   <= 1'b1;
                            mem_be_o   <= '1;
                            mem_addr_o <= dst_i;
                            mem_data_o <= fill_i;
                        end
                    end
                end
                ST_RD_REQ: begin
                    state      <= ST_RD_WAIT;
                    mem_en_o   <= 1'b0;
                    abort_pend <= abort_now;
                end
                ST_RD_WAIT: begin
                    abort_pend <= abort_now;
                    if (mem_ready_i) begin
                        state      <= ST_WR;
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 1'b1;
                        mem_be_o   <= '1;
                        mem_addr_o <= dst_ptr;
                        mem_data_o <= mem_data_i;
                    end
                end
                ST_WR: begin
                    count_o  <= count_next;
                    src_ptr  <= src_ptr + ONE_A;
                    dst_ptr  <= dst_ptr + ONE_A;
                    mem_we_o <= 1'b0;
                    mem_be_o <= '0;
                    if (last_word || abort_now) begin
                        state     <= ST_DONE;
                        mem_en_o  <= 1'b0;
                        done_o    <= 1'b1;
                        aborted_o <= abort_now & ~last_word;
                    end else if (mode == MODE_COPY) begin
                        state      <= ST_RD_REQ;
                        mem_en_o   <= 1'b1;
                        mem_addr_o <= src_ptr + ONE_A;
                    end else begin
                        state      <= ST_WR;
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 1'b1;
                        mem_be_o   <= '1;
                        mem_addr_o <= dst_ptr + ONE_A;
                        mem_data_o <= fill;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                    aborted_o <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
